// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg
// Shared definitions for the clock set controller: FSM state encoding,
// edit_field display codes, BCD field limits, the bit positions of the
// HH/MM/SS fields inside a 24-bit BCD time word, and a helper that
// replaces an invalid captured field with 00.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EDIT_HH = 3'd1,
        ST_EDIT_MM = 3'd2,
        ST_EDIT_SS = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_CLEAR   = 3'd5
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'b00,
        FIELD_HH   = 2'b01,
        FIELD_MM   = 2'b10,
        FIELD_SS   = 2'b11
    } edit_field_t;

    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    localparam int HH_MSB = 23;
    localparam int HH_LSB = 16;
    localparam int MM_MSB = 15;
    localparam int MM_LSB = 8;
    localparam int SS_MSB = 7;
    localparam int SS_LSB = 0;

    // A field is only kept when both digits are decimal and the value does
    // not exceed the field limit. Valid BCD sorts the same way as binary, so
    // a plain magnitude compare against the BCD limit is enough.
    function automatic logic [7:0] sanitize_field(input logic [7:0] value,
                                                  input logic [7:0] max_value);
        logic [7:0] result;
        result = value;
        if ((value[7:4] > 4'd9) || (value[3:0] > 4'd9) || (value > max_value)) begin
            result = 8'h00;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// bcd_field_step
// Combinational +/-1 step of a two-digit BCD field with wrap-around.
// Ports:
//   value      - current BCD field value
//   max_value  - largest legal value (23 for hours, 59 for minutes/seconds)
//   step_up    - request +1 (wraps max_value -> 00)
//   step_down  - request -1 (wraps 00 -> max_value)
//   result     - stepped value; equals value when neither or both requests set
module bcd_field_step
    import clock_ctrl_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] max_value,
    input  logic       step_up,
    input  logic       step_down,
    output logic [7:0] result
);

    // Up and down together cancel. Otherwise the units digit moves and
    // carries/borrows into the tens digit at 9/0, and the whole field wraps
    // at its limits.
    always_comb begin
        result = value;
        if (step_up && !step_down) begin
            if (value == max_value) begin
                result = 8'h00;
            end else if (value[3:0] == 4'd9) begin
                result = {value[7:4] + 4'd1, 4'd0};
            end else begin
                result = {value[7:4], value[3:0] + 4'd1};
            end
        end else if (step_down && !step_up) begin
            if (value == 8'h00) begin
                result = max_value;
            end else if (value[3:0] == 4'd0) begin
                result = {value[7:4] - 4'd1, 4'd9};
            end else begin
                result = {value[7:4], value[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// clock_set_controller
// Turns single-cycle button pulses into a field-by-field HH/MM/SS edit of
// the 24-hour BCD clock, then loads the result with a held set_time strobe.
// A clear in IDLE resets the clock; a clear or inactivity timeout during an
// edit abandons it without loading anything.
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   btn_mode             - enter edit / advance field / commit
//   btn_up, btn_down     - step the current field
//   btn_clear            - reset clock from IDLE, abort an edit
//   time_now[23:0]       - current BCD HHMMSS from the clock
//   time_in[23:0]        - BCD HHMMSS to load into the clock
//   set_time             - load strobe, reset_time - clock reset strobe
//   editing              - high in the edit states and COMMIT
//   edit_field[1:0]      - field being edited, for display blinking
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = 1000,
    parameter int SET_HOLD_CYCLES   = 4,
    parameter int RESET_HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_clear,
    input  logic [23:0] time_now,
    output logic [23:0] time_in,
    output logic        set_time,
    output logic        reset_time,
    output logic        editing,
    output logic [1:0]  edit_field
);

    localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_MAX = (SET_HOLD_CYCLES > RESET_HOLD_CYCLES) ? SET_HOLD_CYCLES
                                                                    : RESET_HOLD_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [23:0]       edit_reg;
    logic [23:0]       edit_reg_next;
    logic [TO_W-1:0]   timeout_cnt;
    logic [TO_W-1:0]   timeout_cnt_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic [23:0]       time_in_next;
    logic              set_time_next;
    logic              reset_time_next;
    logic              editing_next;
    edit_field_t       edit_field_next;
    logic [7:0]        step_value;
    logic [7:0]        step_max;
    logic [7:0]        step_result;

    // Select the field under edit so a single stepper serves all three.
    always_comb begin
        step_value = edit_reg[HH_MSB:HH_LSB];
        step_max   = HH_MAX;
        case (state)
            ST_EDIT_MM: begin
                step_value = edit_reg[MM_MSB:MM_LSB];
                step_max   = MS_MAX;
            end
            ST_EDIT_SS: begin
                step_value = edit_reg[SS_MSB:SS_LSB];
                step_max   = MS_MAX;
            end
            default: begin
                step_value = edit_reg[HH_MSB:HH_LSB];
                step_max   = HH_MAX;
            end
        endcase
    end

    bcd_field_step u_step (
        .value     (step_value),
        .max_value (step_max),
        .step_up   (btn_up),
        .step_down (btn_down),
        .result    (step_result)
    );

    // Next-state and next-output logic. Strobes and counters default to
    // zero so any state change restarts the timeout and hold counters.
    // Button priority in the edit states is clear, then mode, then up/down;
    // a button pulse always beats the timeout in the same cycle. COMMIT
    // spends its first cycle presenting time_in with set_time still low,
    // then holds set_time for SET_HOLD_CYCLES and drops back to IDLE.
    always_comb begin
        state_next       = state;
        edit_reg_next    = edit_reg;
        time_in_next     = time_in;
        set_time_next    = 1'b0;
        reset_time_next  = 1'b0;
        timeout_cnt_next = '0;
        hold_cnt_next    = '0;

        case (state)
            ST_IDLE: begin
                if (btn_clear) begin
                    state_next      = ST_CLEAR;
                    reset_time_next = 1'b1;
                end else if (btn_mode) begin
                    edit_reg_next = {sanitize_field(time_now[HH_MSB:HH_LSB], HH_MAX),
                                     sanitize_field(time_now[MM_MSB:MM_LSB], MS_MAX),
                                     sanitize_field(time_now[SS_MSB:SS_LSB], MS_MAX)};
                    state_next    = ST_EDIT_HH;
                end
            end

            ST_EDIT_HH, ST_EDIT_MM, ST_EDIT_SS: begin
                if (btn_clear) begin
                    state_next = ST_IDLE;
                end else if (btn_mode) begin
                    case (state)
                        ST_EDIT_HH: state_next = ST_EDIT_MM;
                        ST_EDIT_MM: state_next = ST_EDIT_SS;
                        default: begin
                            state_next   = ST_COMMIT;
                            time_in_next = edit_reg;
                        end
                    endcase
                end else if (btn_up || btn_down) begin
                    case (state)
                        ST_EDIT_HH: edit_reg_next[HH_MSB:HH_LSB] = step_result;
                        ST_EDIT_MM: edit_reg_next[MM_MSB:MM_LSB] = step_result;
                        default:    edit_reg_next[SS_MSB:SS_LSB] = step_result;
                    endcase
                end else if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    timeout_cnt_next = timeout_cnt + TO_W'(1);
                end
            end

            ST_COMMIT: begin
                if (hold_cnt == HOLD_W'(SET_HOLD_CYCLES)) begin
                    state_next = ST_IDLE;
                end else begin
                    set_time_next = 1'b1;
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end

            ST_CLEAR: begin
                if (hold_cnt == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    reset_time_next = 1'b1;
                    hold_cnt_next   = hold_cnt + HOLD_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        editing_next = (state_next == ST_EDIT_HH) || (state_next == ST_EDIT_MM) ||
                       (state_next == ST_EDIT_SS) || (state_next == ST_COMMIT);
        case (state_next)
            ST_EDIT_HH: edit_field_next = FIELD_HH;
            ST_EDIT_MM: edit_field_next = FIELD_MM;
            ST_EDIT_SS: edit_field_next = FIELD_SS;
            default:    edit_field_next = FIELD_NONE;
        endcase
    end

    // State, working registers and registered outputs. Outputs are derived
    // from the next state so they always line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            edit_reg    <= 24'h000000;
            timeout_cnt <= '0;
            hold_cnt    <= '0;
            time_in     <= 24'h000000;
            set_time    <= 1'b0;
            reset_time  <= 1'b0;
            editing     <= 1'b0;
            edit_field  <= FIELD_NONE;
        end else begin
            state       <= state_next;
            edit_reg    <= edit_reg_next;
            timeout_cnt <= timeout_cnt_next;
            hold_cnt    <= hold_cnt_next;
            time_in     <= time_in_next;
            set_time    <= set_time_next;
            reset_time  <= reset_time_next;
            editing     <= editing_next;
            edit_field  <= edit_field_next;
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller
// Directed bench for clock_set_controller. Expected load values are queued
// when a commit is started and compared by a monitor when set_time rises.
module tb_clock_set_controller;

    logic        clk;
    logic        reset;
    logic        btn_mode;
    logic        btn_up;
    logic        btn_down;
    logic        btn_clear;
    logic [23:0] time_now;
    logic [23:0] time_in;
    logic        set_time;
    logic        reset_time;
    logic        editing;
    logic [1:0]  edit_field;

    int          checks = 0;
    int          errors = 0;
    int          set_rises = 0;
    int          set_len = 0;
    logic        prev_set = 1'b0;
    logic [23:0] sb[$];

    clock_set_controller #(
        .TIMEOUT_CYCLES    (1000),
        .SET_HOLD_CYCLES   (4),
        .RESET_HOLD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_clear  (btn_clear),
        .time_now   (time_now),
        .time_in    (time_in),
        .set_time   (set_time),
        .reset_time (reset_time),
        .editing    (editing),
        .edit_field (edit_field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [23:0] observed,
                               input logic [23:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle button pulse; returns at the negedge after the
    // posedge that sampled it, where the resulting outputs are visible.
    task automatic applyStimulus(input logic m, input logic u, input logic d, input logic c);
        @(negedge clk);
        btn_mode  = m;
        btn_up    = u;
        btn_down  = d;
        btn_clear = c;
        @(negedge clk);
        btn_mode  = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_clear = 1'b0;
    endtask

    // From EDIT_SS: queues the expected load, presses mode and checks the
    // COMMIT entry cycle, the first set_time cycle and the return to IDLE.
    task automatic runCommit(input logic [23:0] expected_time);
        sb.push_back(expected_time);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("commit_entry_editing", {23'd0, editing}, 24'd1);
        checkOutput("commit_entry_field", {22'd0, edit_field}, 24'd0);
        checkOutput("commit_entry_set", {23'd0, set_time}, 24'd0);
        checkOutput("commit_entry_time_in", time_in, expected_time);
        @(negedge clk);
        checkOutput("commit_set_rise", {23'd0, set_time}, 24'd1);
        repeat (4) @(negedge clk);
        checkOutput("commit_set_fall", {23'd0, set_time}, 24'd0);
        checkOutput("commit_done_editing", {23'd0, editing}, 24'd0);
    endtask

    // Scoreboard monitor: pops the expected load on each set_time rise,
    // measures the strobe length and watches for overlapping strobes.
    always @(negedge clk) begin
        if (set_time || reset_time) begin
            checkOutput("strobe_exclusive", {23'd0, set_time & reset_time}, 24'd0);
        end
        if (set_time && !prev_set) begin
            set_rises++;
            set_len = 1;
            checkOutput("sb_pending", {23'd0, sb.size() > 0}, 24'd1);
            if (sb.size() > 0) begin
                checkOutput("sb_time_in", time_in, sb.pop_front());
            end
        end else if (set_time) begin
            set_len++;
        end
        if (!set_time && prev_set && !reset) begin
            checkOutput("set_hold_len", 24'(set_len), 24'd4);
        end
        prev_set = set_time;
    end

    initial begin
        int saved_rises;
        int n;

        reset     = 1'b1;
        btn_mode  = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_clear = 1'b0;
        time_now  = 24'h000000;
        repeat (2) @(negedge clk);
        checkOutput("rst_time_in", time_in, 24'h000000);
        checkOutput("rst_set_time", {23'd0, set_time}, 24'd0);
        checkOutput("rst_reset_time", {23'd0, reset_time}, 24'd0);
        checkOutput("rst_editing", {23'd0, editing}, 24'd0);
        checkOutput("rst_edit_field", {22'd0, edit_field}, 24'd0);
        reset = 1'b0;

        $display("[TB] edit and commit");
        time_now = 24'h123456;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("enter_editing", {23'd0, editing}, 24'd1);
        checkOutput("enter_field_hh", {22'd0, edit_field}, 24'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("field_mm", {22'd0, edit_field}, 24'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("field_ss", {22'd0, edit_field}, 24'd3);
        runCommit(24'h133356);

        $display("[TB] wrap boundaries");
        time_now = 24'h235900;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        runCommit(24'h000059);

        $display("[TB] digit carry and sanitization");
        time_now = 24'h09FF45;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCommit(24'h100045);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCommit(24'h090045);
        time_now = 24'h245960;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCommit(24'h005900);

        $display("[TB] abort by clear in EDIT_MM");
        saved_rises = set_rises;
        time_now = 24'h111111;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("abort_clear_editing", {23'd0, editing}, 24'd0);
        checkOutput("abort_clear_field", {22'd0, edit_field}, 24'd0);
        repeat (8) @(negedge clk);
        checkOutput("abort_clear_no_set", 24'(set_rises), 24'(saved_rises));
        checkOutput("abort_clear_time_in", time_in, 24'h005900);

        $display("[TB] abort by timeout in EDIT_SS");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_field_ss", {22'd0, edit_field}, 24'd3);
        n = 0;
        while (editing && n < 1100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", 24'(n), 24'd1000);
        checkOutput("timeout_field", {22'd0, edit_field}, 24'd0);
        checkOutput("timeout_no_set", 24'(set_rises), 24'(saved_rises));

        $display("[TB] clear in IDLE");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clear_reset_1", {23'd0, reset_time}, 24'd1);
        checkOutput("clear_set_1", {23'd0, set_time}, 24'd0);
        @(negedge clk);
        checkOutput("clear_reset_2", {23'd0, reset_time}, 24'd1);
        @(negedge clk);
        checkOutput("clear_reset_end", {23'd0, reset_time}, 24'd0);
        checkOutput("clear_editing", {23'd0, editing}, 24'd0);

        $display("[TB] button priorities");
        time_now = 24'h123456;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("prio_mode_over_up", {22'd0, edit_field}, 24'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("prio_up_down_field", {22'd0, edit_field}, 24'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCommit(24'h123456);

        $display("[TB] reset during commit");
        time_now = 24'h010203;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sb.push_back(24'h010203);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rstc_set_first", {23'd0, set_time}, 24'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstc_set_time", {23'd0, set_time}, 24'd0);
        checkOutput("rstc_time_in", time_in, 24'h000000);
        checkOutput("rstc_editing", {23'd0, editing}, 24'd0);
        checkOutput("rstc_field", {22'd0, edit_field}, 24'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("rstc_no_reload", {23'd0, set_time}, 24'd0);

        checkOutput("sb_drained", 24'(sb.size()), 24'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
